ofdm_serial_transmitter: RTL and testbench
==========================================

Name: ofdm_serial_transmitter

Overview:
- Transmit-side counterpart of the 802.11a serial Receiver.
- Emits a 96-bit preamble, then scrambled, rate-1/2 convolutionally coded data bits (K=7, generators 133/171 octal), then a 6-bit zero tail.
- Runs on one clock at the coded-bit rate. Each preamble bit is held for 2 cycles, so the preamble runs at half the coded rate, as the Receiver expects.

Parameters:
- PREAMBLE, 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA, preamble pattern; bit 95 is sent first.
- SCRAMBLE, 1, 1 = scrambler enabled, 0 = data bypasses the scrambler.
- SEED, 7'b1011101, scrambler initial state, loaded at each Start; must be nonzero.
- LEN_W, 12, width of Length.

Ports:
- Clock  input  1  system clock; all state is updated on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  frame request; sampled only in IDLE.
- Length  input  LEN_W  number of data bits; latched when Start is accepted.
- DataIn  input  1  data bit.
- DataValid  input  1  DataIn is valid.
- DataReady  output  1  block consumes DataIn this cycle; combinational from state.
- Output  output  1  serial line bit, registered.
- OutValid  output  1  Output carries frame content, registered.
- Busy  output  1  state is not IDLE.
- Done  output  1  one-cycle pulse after the last tail bit.
- Error  output  1  sticky underrun flag; cleared at Start.

Behaviour:
- Reset (synchronous, highest priority, may hit mid-frame): next state is IDLE. Output, OutValid, Done and Error go to 0. Counters go to 0. Encoder shift register goes to 0. Scrambler goes to SEED.
- States: IDLE -> PREAMBLE -> DATA -> TAIL -> DONE -> IDLE.
- IDLE:
  - Output=0, OutValid=0.
  - On the edge that samples Start=1: latch Length, load scrambler with SEED, clear the encoder register, clear Error, go to PREAMBLE.
  - Start is ignored in all other states.
- PREAMBLE:
  - 192 cycles; a counter runs 0..191.
  - Output = PREAMBLE[95 - cnt/2], OutValid=1.
  - The first preamble bit is visible in the cycle after the Start edge.
- DATA handshake:
  - DataReady=1 exactly on phase-0 cycles. The first phase-0 cycle is the last preamble cycle (cnt=191). Phase-0 cycles then alternate with phase-1 cycles.
  - On a phase-0 edge: take bit u. u = DataIn if DataValid=1. Otherwise u = 0 and Error is set sticky (underrun; the line never stalls).
  - Scramble: f = x7^x4, s = u^f, shift f into x1 (skipped when SCRAMBLE=0, where s = u).
  - Encode: A = s^d1^d2^d3^d6... more precisely, g0 taps (d[n],d[n-2],d[n-3],d[n-5],d[n-6]) give A; g1 taps (d[n],d[n-1],d[n-2],d[n-3],d[n-6]) give B.
  - Output<=A, hold B, shift s into the encoder register.
  - The next (phase-1) edge loads Output<=B.
  - A bit accepted at edge e appears as A after e and as B after e+1.
  - After Length bits: go to TAIL. If Length=0, DATA is skipped and TAIL follows PREAMBLE directly.
- TAIL:
  - Six zero bits are encoded with the same phase timing: 12 output cycles.
  - Tail bits bypass the scrambler; DataReady=0.
- DONE:
  - One cycle: Done=1, Output=0, OutValid=0, Busy=1.
  - Next state IDLE. Error keeps its value until the next Start.
- Widths: the data-bit counter is LEN_W bits and counts to Length-1 with no wrap.
- Total frame: 192 + 2·(Length+6) cycles of OutValid=1.
- Simultaneous Reset and Start: Reset wins.
- DataValid outside DataReady cycles is ignored.

Test Plan:
- Reset check: assert Reset mid-DATA for 1 cycle -> next cycle Output=0, OutValid=0, Busy=0, Error=0. Start then produces a full, correct frame.
- Preamble timing: Start at edge 0 with default PREAMBLE -> Output reads 1,1,0,0,1,1,... for cycles 1..192. DataReady is high only in cycle 192 within that span.
- Impulse response: SCRAMBLE=0, Length=1, DataIn=1 -> 14 coded bits 11 01 11 11 00 10 11, then Done pulses once. OutValid is high for 206 cycles.
- Length=0 -> 12 zero coded bits after the preamble, DataReady never high, Done pulses.
- Scrambler: SCRAMBLE=1, SEED=7'b1111111, Length=8, DataIn=0, DataValid=1 -> scrambled stream 00001110. First 16 coded bits: 00 00 00 00 11 10 01 01.
- Underrun: DataValid=0 on the 3rd DataReady cycle -> Error=1 from the next cycle, and a 0 bit is encoded in its place. The frame length is unchanged. Error stays 1 through DONE and clears on the next Start.

Source files
------------

// File: rtl/ofdm_serial_transmitter.sv
// ============================================================================
// Module   : ofdm_serial_transmitter
// Brief    : Serial 802.11a-style transmitter: preamble, scrambled K=7 r=1/2
//            convolutional data, zero tail, at the coded-bit rate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ofdm_serial_transmitter #(
    parameter logic [95:0] PREAMBLE = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA,
    parameter bit          SCRAMBLE = 1'b1,
    parameter logic [6:0]  SEED     = 7'b1011101,
    parameter int          LEN_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_length,
    input  logic             i_data_in,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    output logic             o_output,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_TAIL     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [7:0] c_LAST_PRE  = 8'd191;
    localparam logic [2:0] c_TAIL_BITS = 3'd6;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_phase, w_phase_nxt;
    logic [LEN_W-1:0] r_bit_idx, w_bit_idx_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic [2:0]       r_tail_cnt, w_tail_cnt_nxt;
    logic [6:0]       r_scr, w_scr_nxt;
    logic [5:0]       r_enc, w_enc_nxt;
    logic             r_code_b, w_code_b_nxt;
    logic             r_out, w_out_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_error, w_error_nxt;

    logic [7:0] w_cnt_inc;
    logic [6:0] w_pre_idx;
    logic       w_data_slot;
    logic       w_fb;
    logic       w_s;
    logic       w_code_a;
    logic       w_code_b;

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_pre_idx = 7'd95 - 7'(w_cnt_inc >> 1);

    // A data bit is taken on the last preamble cycle and on every DATA phase-0 cycle.
    assign w_data_slot = ((r_state == S_PREAMBLE) && (r_cnt == c_LAST_PRE) && (r_len != '0))
                       || ((r_state == S_DATA) && !r_phase);

    // r_scr[k-1] holds x(k); r_enc[k-1] holds d[n-k].
    assign w_fb     = r_scr[6] ^ r_scr[3];
    assign w_s      = w_data_slot ? ((i_data_valid & i_data_in) ^ (SCRAMBLE ? w_fb : 1'b0)) : 1'b0;
    assign w_code_a = w_s ^ r_enc[1] ^ r_enc[2] ^ r_enc[4] ^ r_enc[5];
    assign w_code_b = w_s ^ r_enc[0] ^ r_enc[1] ^ r_enc[2] ^ r_enc[5];

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_phase_nxt     = r_phase;
        w_bit_idx_nxt   = r_bit_idx;
        w_len_nxt       = r_len;
        w_tail_cnt_nxt  = r_tail_cnt;
        w_scr_nxt       = r_scr;
        w_enc_nxt       = r_enc;
        w_code_b_nxt    = r_code_b;
        w_error_nxt     = r_error;
        w_out_nxt       = 1'b0;
        w_out_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt     = S_PREAMBLE;
                    w_cnt_nxt       = 8'd0;
                    w_phase_nxt     = 1'b0;
                    w_bit_idx_nxt   = '0;
                    w_tail_cnt_nxt  = 3'd0;
                    w_len_nxt       = i_length;
                    w_scr_nxt       = SEED;
                    w_enc_nxt       = 6'd0;
                    w_error_nxt     = 1'b0;
                    w_out_nxt       = PREAMBLE[95];
                    w_out_valid_nxt = 1'b1;
                end
            end
            S_PREAMBLE: begin
                w_out_valid_nxt = 1'b1;
                w_cnt_nxt       = w_cnt_inc;
                if (r_cnt != c_LAST_PRE) begin
                    w_out_nxt = PREAMBLE[w_pre_idx];
                end else begin
                    // Last preamble cycle doubles as the first coded phase-0 slot.
                    w_out_nxt    = w_code_a;
                    w_code_b_nxt = w_code_b;
                    w_enc_nxt    = {r_enc[4:0], w_s};
                    w_phase_nxt  = 1'b1;
                    w_state_nxt  = (r_len != '0) ? S_DATA : S_TAIL;
                end
            end
            S_DATA: begin
                w_out_valid_nxt = 1'b1;
                if (!r_phase) begin
                    w_out_nxt    = w_code_a;
                    w_code_b_nxt = w_code_b;
                    w_enc_nxt    = {r_enc[4:0], w_s};
                    w_phase_nxt  = 1'b1;
                end else begin
                    w_out_nxt   = r_code_b;
                    w_phase_nxt = 1'b0;
                    if (r_bit_idx == r_len - LEN_W'(1)) begin
                        w_state_nxt    = S_TAIL;
                        w_tail_cnt_nxt = 3'd0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + LEN_W'(1);
                    end
                end
            end
            S_TAIL: begin
                if (!r_phase) begin
                    if (r_tail_cnt == c_TAIL_BITS) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_out_valid_nxt = 1'b1;
                        w_out_nxt       = w_code_a;
                        w_code_b_nxt    = w_code_b;
                        w_enc_nxt       = {r_enc[4:0], 1'b0};
                        w_phase_nxt     = 1'b1;
                    end
                end else begin
                    w_out_valid_nxt = 1'b1;
                    w_out_nxt       = r_code_b;
                    w_phase_nxt     = 1'b0;
                    w_tail_cnt_nxt  = r_tail_cnt + 3'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_data_slot) begin
            if (SCRAMBLE) begin
                w_scr_nxt = {r_scr[5:0], w_fb};
            end
            if (!i_data_valid) begin
                w_error_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_phase     <= 1'b0;
            r_bit_idx   <= '0;
            r_len       <= '0;
            r_tail_cnt  <= 3'd0;
            r_scr       <= SEED;
            r_enc       <= 6'd0;
            r_code_b    <= 1'b0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_len       <= w_len_nxt;
            r_tail_cnt  <= w_tail_cnt_nxt;
            r_scr       <= w_scr_nxt;
            r_enc       <= w_enc_nxt;
            r_code_b    <= w_code_b_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_error     <= w_error_nxt;
        end
    end

    assign o_data_ready = w_data_slot;
    assign o_output     = r_out;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ofdm_serial_transmitter.sv
// ============================================================================
// Module   : tb_ofdm_serial_transmitter
// Brief    : Randomized frame bench for ofdm_serial_transmitter against a
//            bit-list reference model (three parameterizations in parallel).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ofdm_serial_transmitter;

    localparam logic [95:0] c_PRE      = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [6:0]  c_SEED_DEF = 7'b1011101;
    localparam int          c_MAXB     = 256;
    localparam int          c_NO_ERR   = 1 << 30;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [11:0] i_length;
    logic        i_data_in;
    logic        i_data_valid;
    logic [2:0]  o_data_ready, o_output, o_out_valid, o_busy, o_done, o_error;

    int n_checks = 0;
    int n_errors = 0;
    bit last_err = 1'b0;

    bit sv [0:c_MAXB-1];
    bit exp_c [0:2][0:c_MAXB-1];

    // Instance 0: defaults; 1: scrambler bypassed; 2: all-ones seed.
    ofdm_serial_transmitter u_dut_def (
        .clk(clk), .rst(rst), .i_start(i_start), .i_length(i_length),
        .i_data_in(i_data_in), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready[0]), .o_output(o_output[0]),
        .o_out_valid(o_out_valid[0]), .o_busy(o_busy[0]),
        .o_done(o_done[0]), .o_error(o_error[0])
    );

    ofdm_serial_transmitter #(.SCRAMBLE(1'b0)) u_dut_nos (
        .clk(clk), .rst(rst), .i_start(i_start), .i_length(i_length),
        .i_data_in(i_data_in), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready[1]), .o_output(o_output[1]),
        .o_out_valid(o_out_valid[1]), .o_busy(o_busy[1]),
        .o_done(o_done[1]), .o_error(o_error[1])
    );

    ofdm_serial_transmitter #(.SEED(7'h7F)) u_dut_ones (
        .clk(clk), .rst(rst), .i_start(i_start), .i_length(i_length),
        .i_data_in(i_data_in), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready[2]), .o_output(o_output[2]),
        .o_out_valid(o_out_valid[2]), .o_busy(o_busy[2]),
        .o_done(o_done[2]), .o_error(o_error[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    function automatic bit s_at(int i);
        return (i < 0) ? 1'b0 : sv[i];
    endfunction

    task automatic check_idle(input int k, input bit e_err);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("idle_out%0d", d),   k, 32'(o_output[d]),     32'd0);
            check($sformatf("idle_vld%0d", d),   k, 32'(o_out_valid[d]),  32'd0);
            check($sformatf("idle_busy%0d", d),  k, 32'(o_busy[d]),       32'd0);
            check($sformatf("idle_done%0d", d),  k, 32'(o_done[d]),       32'd0);
            check($sformatf("idle_ready%0d", d), k, 32'(o_data_ready[d]), 32'd0);
            check($sformatf("idle_err%0d", d),   k, 32'(o_error[d]),      32'(e_err));
        end
    endtask

    // mode: 0 random data, 1 all ones, 2 all zeros, 3 random data with random gaps.
    task automatic run_frame(input int len, input int mode, input int ur_idx, input int rst_at);
        bit          dd[$];
        bit          dv[$];
        bit          x [1:7];
        bit          u_i, f, v, e_vld, e_rdy, e_done, e_err, e_out;
        logic [6:0]  seed;
        logic [95:0] pre;
        int          nb, total, err_from, idx;

        pre      = c_PRE;
        err_from = c_NO_ERR;
        for (int i = 0; i < len; i++) begin
            dd.push_back(mode == 1 ? 1'b1 : (mode == 2 ? 1'b0 : 1'($urandom_range(0, 1))));
            v = (i != ur_idx) && (mode != 3 || $urandom_range(0, 7) != 0);
            dv.push_back(v);
            if (!v && err_from == c_NO_ERR) err_from = 193 + 2 * i;
        end
        nb    = len + 6;
        total = 193 + 2 * nb;

        for (int cfg = 0; cfg < 3; cfg++) begin
            seed = (cfg == 2) ? 7'h7F : c_SEED_DEF;
            for (int k = 1; k <= 7; k++) x[k] = seed[k-1];
            for (int i = 0; i < len; i++) begin
                u_i = dv[i] ? dd[i] : 1'b0;
                if (cfg == 1) begin
                    sv[i] = u_i;
                end else begin
                    f     = x[7] ^ x[4];
                    sv[i] = u_i ^ f;
                    for (int k = 7; k >= 2; k--) x[k] = x[k-1];
                    x[1] = f;
                end
            end
            for (int i = len; i < nb; i++) sv[i] = 1'b0;
            for (int n = 0; n < nb; n++) begin
                exp_c[cfg][2*n]   = s_at(n) ^ s_at(n-2) ^ s_at(n-3) ^ s_at(n-5) ^ s_at(n-6);
                exp_c[cfg][2*n+1] = s_at(n) ^ s_at(n-1) ^ s_at(n-2) ^ s_at(n-3) ^ s_at(n-6);
            end
        end

        i_start      = 1'b1;
        i_length     = len[11:0];
        i_data_in    = 1'($urandom_range(0, 1));
        i_data_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;

        for (int k = 1; k <= total; k++) begin
            e_vld  = (k <= 192 + 2 * nb);
            e_rdy  = (k >= 192) && (k < 192 + 2 * len) && ((k - 192) % 2 == 0);
            e_done = (k == total);
            e_err  = (k >= err_from);
            for (int d = 0; d < 3; d++) begin
                if (k <= 192)  e_out = pre[95 - (k - 1) / 2];
                else if (e_vld) e_out = exp_c[d][k - 193];
                else           e_out = 1'b0;
                check($sformatf("out%0d", d),   k, 32'(o_output[d]),     32'(e_out));
                check($sformatf("vld%0d", d),   k, 32'(o_out_valid[d]),  32'(e_vld));
                check($sformatf("busy%0d", d),  k, 32'(o_busy[d]),       32'd1);
                check($sformatf("done%0d", d),  k, 32'(o_done[d]),       32'(e_done));
                check($sformatf("ready%0d", d), k, 32'(o_data_ready[d]), 32'(e_rdy));
                check($sformatf("err%0d", d),   k, 32'(o_error[d]),      32'(e_err));
            end

            i_start  = 1'($urandom_range(0, 1));
            i_length = 12'($urandom);
            if (e_rdy) begin
                idx          = (k - 192) / 2;
                i_data_in    = dd[idx];
                i_data_valid = dv[idx];
            end else begin
                i_data_in    = 1'($urandom_range(0, 1));
                i_data_valid = 1'($urandom_range(0, 1));
            end
            if (k == rst_at) begin
                rst     = 1'b1;
                i_start = 1'b1;
            end
            @(posedge clk); #1;
            if (k == rst_at) begin
                rst      = 1'b0;
                i_start  = 1'b0;
                last_err = 1'b0;
                check_idle(k + 1, 1'b0);
                return;
            end
        end

        last_err = (err_from != c_NO_ERR);
        check_idle(total + 1, last_err);
        i_start      = 1'b0;
        i_data_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int j = 0; j < n; j++) begin
            i_start      = 1'b0;
            i_length     = 12'($urandom);
            i_data_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_idle(-1, last_err);
        end
    endtask

    initial begin
        int len, ur;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_length     = 12'd0;
        i_data_in    = 1'b0;
        i_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle(0, 1'b0);
        rst = 1'b0;
        idle_gap(2);

        run_frame(5, 0, -1, 0);
        idle_gap(2);
        run_frame(1, 1, -1, 0);
        idle_gap(1);
        run_frame(0, 0, -1, 0);
        idle_gap(3);
        run_frame(8, 2, -1, 0);
        idle_gap(1);
        run_frame(6, 0, 2, 0);
        idle_gap(2);
        run_frame(10, 0, 1, 200);
        idle_gap(1);
        run_frame(7, 0, -1, 0);
        idle_gap(1);

        rst     = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        i_start  = 1'b0;
        last_err = 1'b0;
        check_idle(0, 1'b0);
        idle_gap(1);

        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(0, 40);
            ur  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 40) : -1;
            run_frame(len, ($urandom_range(0, 1) != 0) ? 3 : 0, ur, 0);
            idle_gap($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
